// File: rtl/seri_mul_feeder.sv
// Operand FIFO feeding a serial multiplier: issue one pair, wait for completion
// (bounded by TIMEOUT), hold the product until downstream accepts it.
module seri_mul_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  output logic [7:0]    mul_a,
  output logic [7:0]    mul_b,
  output logic          en_mul,
  input  logic [15:0]   product,
  input  logic          op_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_product,
  output logic [AW:0]   fifo_cnt,
  output logic          timeout_err,
  input  logic          clr_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  pair_t          mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [1:0]     state;
  logic [CW-1:0]  wait_cnt;
  logic           push, pop, timeout_hit;
  pair_t          head;

  assign in_ready    = (fifo_cnt != (AW+1)'(FIFO_DEPTH));
  assign push        = in_valid && in_ready;
  // The head leaves the FIFO on the same edge that launches the operation.
  assign pop         = (state == S_IDLE) && (fifo_cnt != '0);
  assign head        = mem[rptr];
  assign timeout_hit = (state == S_WAIT) && !op_done && (wait_cnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{a: in_a, b: in_b};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      en_mul      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          state  <= S_ISSUE;
          en_mul <= 1'b1;
          mul_a  <= head.a;
          mul_b  <= head.b;
        end
        S_ISSUE: begin
          en_mul   <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Completion beats the timeout when both land in the same cycle.
          if (op_done) begin
            out_product <= product;
            out_valid   <= 1'b1;
            state       <= S_HOLD;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (clr_err)     timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_seri_mul_feeder.sv
// Scoreboard bench: pushed pairs feed an issue queue, a serial-multiplier model
// decides each operation's fate, and a monitor checks every delivered result.
module tb_seri_mul_feeder;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_a = '0, in_b = '0, mul_a, mul_b;
  logic        en_mul, op_done, out_valid, out_ready, timeout_err, clr_err;
  logic [15:0] product, out_product;
  logic [2:0]  fifo_cnt;

  seri_mul_feeder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .en_mul(en_mul),
    .product(product), .op_done(op_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .fifo_cnt(fifo_cnt),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  pair_t       pend [$];
  logic [15:0] exp_q [$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, occ = 0, first_push_cyc = 0;
  bit          push_seen = 0, waiting_first = 1, have_push = 0;
  bit          busy = 0, force_hang = 0, or_force = 0;
  bit          prev_stall = 0, prev_en = 0;
  logic [15:0] prev_prod = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Input tap: the reference FIFO is simply the queue of accepted pairs.
  always @(posedge clk) begin
    cyc++;
    if (rstn && in_valid && in_ready) begin
      pend.push_back('{a: in_a, b: in_b});
      push_seen = 1;
      if (waiting_first && !have_push) begin
        first_push_cyc = cyc;
        have_push = 1;
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!rstn) begin
      occ = 0; push_seen = 0; waiting_first = 1; have_push = 0;
      prev_stall = 0; prev_en = 0;
    end else begin
      occ += int'(push_seen);
      push_seen = 0;
      if (en_mul) occ--;
      chk("fifo_cnt", fifo_cnt, occ);
      chk("in_ready", in_ready, occ != DEPTH);
      if (en_mul && waiting_first) begin
        chk("issue_latency", cyc - first_push_cyc, 1);
        waiting_first = 0;
      end
      if (en_mul && (prev_en || out_valid)) chk("en_mul_illegal", 1, 0);
      if (prev_stall) chk("hold_stable", {out_valid, out_product}, {1'b1, prev_prod});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", out_product, 17'h1_0000);
        else chk("result", out_product, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_product;
      prev_en    = en_mul;
    end
  end

  // Serial-multiplier model: op_done lands in WAIT cycle w (0-based), or never.
  task automatic handle();
    pair_t p;
    int    w, r;
    bit    resp, late, aborted;
    busy = 1;
    p = '{a: mul_a, b: mul_b};
    if (pend.size() == 0) chk("issue_without_push", 1, 0);
    else begin
      p = pend.pop_front();
      chk("issue_operands", {mul_a, mul_b}, {p.a, p.b});
    end
    r = $urandom_range(0, 9);
    resp = 1; late = 0;
    if (force_hang || r == 8) begin resp = 0; w = TO; end
    else if (r == 9) begin resp = 0; late = 1; w = TO; end
    else if (r == 6) w = TO - 1;
    else if (r == 7) w = 0;
    else w = $urandom_range(0, 12);
    if (resp) exp_q.push_back(16'(p.a) * 16'(p.b));
    // Holding clr_err through a doomed wait also exercises set-beats-clear.
    else clr_err = 1;
    aborted = 0;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      if (!rstn) begin aborted = 1; break; end
    end
    if (aborted) begin
      clr_err = 0;
      wait (rstn === 1'b1);
      repeat (2) @(negedge clk);
      op_done = 1; product = 16'h1234;
      @(negedge clk);
      op_done = 0;
      busy = 0;
      return;
    end
    if (resp) begin
      op_done = 1; product = 16'(p.a) * 16'(p.b);
      chk("no_err_on_done", timeout_err, 0);
      @(negedge clk);
      op_done = 0; product = 16'($urandom);
    end else begin
      chk("timeout_set", timeout_err, 1);
      if (late) begin op_done = 1; product = 16'($urandom); end
      @(negedge clk);
      op_done = 0;
      chk("timeout_clr", timeout_err, 0);
      clr_err = 0;
    end
    busy = 0;
  endtask

  initial begin
    op_done = 0; product = '0; clr_err = 0;
    forever begin
      @(negedge clk);
      while (rstn && en_mul) handle();
    end
  end

  initial begin
    out_ready = 0;
    wait (rstn === 1'b1);
    repeat (150) begin @(posedge clk); #1; out_ready = or_force | ($urandom_range(0, 3) != 0); end
    @(posedge clk); #1; out_ready = or_force;
    repeat (50) @(posedge clk);
    forever begin @(posedge clk); #1; out_ready = or_force | ($urandom_range(0, 3) != 0); end
  end

  // Called at posedge+1; returns at posedge+1 with in_valid low.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    in_valid = 1; in_a = a; in_b = b;
    while (!in_ready && guard < 300) begin @(posedge clk); #1; guard++; end
    if (guard >= 300) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  function automatic logic [7:0] rnd8();
    int s = $urandom_range(0, 7);
    return (s == 0) ? 8'd0 : (s == 1) ? 8'd255 : 8'($urandom);
  endfunction

  logic [7:0] ta [5] = '{8'd35, 8'd135, 8'd135, 8'd255, 8'd0};
  logic [7:0] tb [5] = '{8'd39, 8'd39, 8'd199, 8'd255, 8'd7};

  initial begin
    int guard;
    #1 rstn = 0;
    #12;
    chk("reset_outputs", {en_mul, mul_a, mul_b, out_valid, out_product, timeout_err, fifo_cnt}, '0);
    chk("reset_in_ready", in_ready, 1);
    #9 rstn = 1;
    @(posedge clk); #1;
    push(8'd45, 8'd89);
    repeat (40) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) push(ta[i], tb[i]);
    for (int i = 0; i < 60; i++) begin
      push(rnd8(), rnd8());
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    or_force = 1;
    guard = 0;
    while ((pend.size() != 0 || exp_q.size() != 0 || busy || out_valid) && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 2000) chk("drain_timeout", 0, 1);
    // Reset mid-WAIT with two pairs still queued.
    force_hang = 1;
    for (int i = 0; i < 3; i++) push(8'(i + 3), 8'(i + 11));
    repeat (6) @(posedge clk);
    chk("queued_before_reset", fifo_cnt, 2);
    @(negedge clk); #2;
    rstn = 0;
    pend.delete(); exp_q.delete();
    #1;
    chk("midwait_reset", {en_mul, mul_a, mul_b, out_valid, out_product, timeout_err, fifo_cnt}, '0);
    @(negedge clk); #2;
    rstn = 1; force_hang = 0;
    repeat (3 * TO) @(posedge clk);
    chk("final_queues", {pend.size(), exp_q.size()}, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
